seqsched: RTL

Single-clock scheduler that shares one arithmetic address-sequence generator among `NREQ` requesters (scanline fetch, sprite fetch, palette load). Each requester posts a run (start word, length). The block grants runs round-robin and emits `start, start+STRIDE, …` one word per accepted handshake toward video memory, then signals completion to the owner. It sits between the fetch units and the memory-read port, upstream of the output FIFOs.

---
 rtl/seqsched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seqsched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one strided address generator among NREQ requesters.
// First word 1 cycle after grant, 2 cycles overhead per run; AddrOut/AddrValid hold while AddrReady is low.
module seqsched #(
    parameter int NREQ   = 2,
    parameter int AWIDTH = 8,
    parameter int LWIDTH = 4,
    parameter int STRIDE = 1,
    parameter int IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic [NREQ-1:0]        ReqValid,
    input  logic [NREQ*AWIDTH-1:0] ReqStart,
    input  logic [NREQ*LWIDTH-1:0] ReqLen,
    output logic [NREQ-1:0]        ReqAck,
    output logic [NREQ-1:0]        Done,
    output logic [AWIDTH-1:0]      AddrOut,
    output logic                   AddrValid,
    input  logic                   AddrReady,
    output logic [IDXW-1:0]        Owner,
    output logic                   Busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} stateE;

    stateE             state, stateNxt;
    logic [IDXW-1:0]   ptr, ptrNxt;
    logic [AWIDTH-1:0] addrQ, addrNxt;
    logic              addrVldQ, addrVldNxt;
    logic [LWIDTH-1:0] remQ, remNxt;
    logic [IDXW-1:0]   ownerQ, ownerNxt;
    logic [NREQ-1:0]   ackQ, ackNxt;
    logic [NREQ-1:0]   doneQ, doneNxt;
    logic              busyQ, busyNxt;
    logic              zeroRunQ, zeroRunNxt;

    logic              grantVld;
    logic [IDXW-1:0]   grantIdx;

    logic [AWIDTH-1:0] startArr [NREQ];
    logic [LWIDTH-1:0] lenArr   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : gUnpack
        assign startArr[i] = ReqStart[i*AWIDTH +: AWIDTH];
        assign lenArr[i]   = ReqLen[i*LWIDTH +: LWIDTH];
    end

    // (base + ofs) mod NREQ for base, ofs < NREQ; works for non power-of-two NREQ.
    function automatic logic [IDXW-1:0] wrapIdx(input logic [IDXW-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDXW'(sum);
    endfunction

    always_comb begin
        grantVld = 1'b0;
        grantIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grantVld && ReqValid[wrapIdx(ptr, k)]) begin
                grantVld = 1'b1;
                grantIdx = wrapIdx(ptr, k);
            end
        end
    end

    always_comb begin
        stateNxt   = state;
        ptrNxt     = ptr;
        addrNxt    = addrQ;
        addrVldNxt = addrVldQ;
        remNxt     = remQ;
        ownerNxt   = ownerQ;
        zeroRunNxt = zeroRunQ;
        ackNxt     = '0;
        doneNxt    = '0;
        case (state)
            IDLE: begin
                if (grantVld) begin
                    addrNxt          = startArr[grantIdx];
                    remNxt           = lenArr[grantIdx];
                    ownerNxt         = grantIdx;
                    ptrNxt           = wrapIdx(grantIdx, 1);
                    ackNxt[grantIdx] = 1'b1;
                    zeroRunNxt       = (lenArr[grantIdx] == '0);
                    if (lenArr[grantIdx] != '0) begin
                        stateNxt   = RUN;
                        addrVldNxt = 1'b1;
                    end else begin
                        stateNxt = DONE;
                    end
                end
            end
            RUN: begin
                if (addrVldQ && AddrReady) begin
                    addrNxt = addrQ + AWIDTH'(STRIDE);
                    remNxt  = remQ - LWIDTH'(1);
                    if (remQ == LWIDTH'(1)) begin
                        addrVldNxt      = 1'b0;
                        stateNxt        = DONE;
                        doneNxt[ownerQ] = 1'b1;
                    end
                end
            end
            DONE: begin
                stateNxt = IDLE;
                // An empty run pulses Done one cycle late so it never coincides with its ReqAck.
                if (zeroRunQ) begin
                    doneNxt[ownerQ] = 1'b1;
                end
            end
            default: stateNxt = IDLE;
        endcase
        busyNxt = (stateNxt != IDLE);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= IDLE;
            ptr      <= '0;
            addrQ    <= '0;
            addrVldQ <= 1'b0;
            remQ     <= '0;
            ownerQ   <= '0;
            ackQ     <= '0;
            doneQ    <= '0;
            busyQ    <= 1'b0;
            zeroRunQ <= 1'b0;
        end else begin
            state    <= stateNxt;
            ptr      <= ptrNxt;
            addrQ    <= addrNxt;
            addrVldQ <= addrVldNxt;
            remQ     <= remNxt;
            ownerQ   <= ownerNxt;
            ackQ     <= ackNxt;
            doneQ    <= doneNxt;
            busyQ    <= busyNxt;
            zeroRunQ <= zeroRunNxt;
        end
    end

    assign ReqAck    = ackQ;
    assign Done      = doneQ;
    assign AddrOut   = addrQ;
    assign AddrValid = addrVldQ;
    assign Owner     = ownerQ;
    assign Busy      = busyQ;

endmodule
